cop0_regfile: RTL

Coprocessor-0 register file and exception-state keeper for the multi-cycle reference CPU. It is consumed by the S_COP0_ACCESS (MFC0/MTC0), S_EXCEPTION_RETURN (ERET) and exception-entry states of the control FSM. It holds BadVAddr, Count, Compare, Status, Cause and EPC, runs the Count/Compare timer, and computes the pending-interrupt request that the FSM polls before each fetch.

---
 rtl/cop0_regfile_pkg.sv | 56 +++++
 rtl/cop0_regfile_timer.sv | 49 ++++
 rtl/cop0_regfile.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cop0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause layouts,
// the exception-code enum and a helper for the EPC value on exception entry.
package cop0_regfile_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_MOD  = 5'h01,
    EXC_TLBL = 5'h02,
    EXC_TLBS = 5'h03,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_IBE  = 5'h06,
    EXC_DBE  = 5'h07,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_CPU  = 5'h0B,
    EXC_OV   = 5'h0C,
    EXC_TR   = 5'h0D
  } exc_code_e;

  // Status: BEV at bit 22, IM at 15:8, EXL at 1, IE at 0; everything else zero
  typedef struct packed {
    logic [8:0] zero_hi;
    logic       bev;
    logic [5:0] zero_mid;
    logic [7:0] im;
    logic [5:0] zero_lo;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  // Cause: BD 31, TI 30, IP 15:8, ExcCode 6:2; everything else zero
  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] zero_hi;
    logic [7:0]  ip;
    logic        zero_7;
    logic [4:0]  exc_code;
    logic [1:0]  zero_lo;
  } cp0_cause_t;

  // A delay-slot fault restarts at the branch, one word earlier
  function automatic logic [31:0] epc_for(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cop0_regfile_timer.sv
// Count/Compare timer: Count advances every second cycle via a phase flop,
// TI latches when Count matches Compare and is cleared by a Compare write.
module cop0_regfile_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  logic        r_phase;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  // Phase flop: free-running divide-by-two, never disturbed by Count writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_phase <= 1'b0;
    else       r_phase <= ~r_phase;
  end

  // Count: a software write overrides the increment in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_count <= '0;
    else if (i_count_we) r_count <= i_wr_data;
    else if (r_phase)    r_count <= r_count + 32'd1;
  end

  // Compare register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_compare <= '0;
    else if (i_compare_we) r_compare <= i_wr_data;
  end

  // TI: a Compare write clears it even if the match happens the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_ti <= 1'b0;
    else if (i_compare_we)           r_ti <= 1'b0;
    else if (r_count == r_compare)   r_ti <= 1'b1;
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cop0_regfile.sv
// Coprocessor-0 register file: MFC0/MTC0 access, exception entry, ERET,
// Count/Compare timer and the pending-interrupt request for the control FSM.
module cop0_regfile
  import cop0_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  logic        ex_valid,
  input  logic [4:0]  ex_code,
  input  logic [31:0] ex_pc,
  input  logic        ex_bd,
  input  logic        ex_badvaddr_valid,
  input  logic [31:0] ex_badvaddr,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] epc,
  output logic        int_pending
);

  logic        r_ie;
  logic        r_exl;
  logic [7:0]  r_im;
  logic        r_bd;
  logic [1:0]  r_sw_ip;
  exc_code_e   r_exc_code;
  logic [5:0]  r_hw_int;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic        w_wr;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [7:0]  w_ip;
  cp0_status_t w_status;
  cp0_cause_t  w_cause;

  // An MTC0 only lands when no exception or ERET claims the same cycle
  assign w_wr = wr_en & ~ex_valid & ~eret & (wr_sel == 3'd0);

  cop0_regfile_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_count_we   (w_wr && (wr_addr == CP0_COUNT)),
    .i_compare_we (w_wr && (wr_addr == CP0_COMPARE)),
    .i_wr_data    (wr_data),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  // Synchronise the external interrupt lines into Cause.IP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_hw_int <= '0;
    else       r_hw_int <= hw_int;
  end

  // Exception entry, ERET and MTC0 updates, in that priority order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ie       <= 1'b0;
      r_exl      <= 1'b0;
      r_im       <= '0;
      r_bd       <= 1'b0;
      r_sw_ip    <= '0;
      r_exc_code <= EXC_INT;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else if (ex_valid) begin
      r_exc_code <= exc_code_e'(ex_code);
      // Nested exceptions keep the original return point
      if (!r_exl) begin
        r_epc <= epc_for(ex_pc, ex_bd);
        r_bd  <= ex_bd;
        r_exl <= 1'b1;
      end
      if (ex_badvaddr_valid) r_badvaddr <= ex_badvaddr;
    end else if (eret) begin
      r_exl <= 1'b0;
    end else if (w_wr) begin
      case (wr_addr)
        CP0_BADVADDR: r_badvaddr <= wr_data;
        CP0_STATUS: begin
          r_ie  <= wr_data[0];
          r_exl <= wr_data[1];
          r_im  <= wr_data[15:8];
        end
        CP0_CAUSE:    r_sw_ip <= wr_data[9:8];
        CP0_EPC:      r_epc   <= wr_data;
        default: ;
      endcase
    end
  end

  // IP[7] shares the top hardware line with the timer interrupt
  assign w_ip = {r_hw_int[5] | w_ti, r_hw_int[4:0], r_sw_ip};

  // Assemble the architectural Status/Cause views and the MFC0 read mux
  always_comb begin
    w_status          = '0;
    w_status.bev      = 1'b1;
    w_status.im       = r_im;
    w_status.exl      = r_exl;
    w_status.ie       = r_ie;
    w_cause           = '0;
    w_cause.bd        = r_bd;
    w_cause.ti        = w_ti;
    w_cause.ip        = w_ip;
    w_cause.exc_code  = r_exc_code;
    rd_data           = '0;
    if (rd_sel == 3'd0) begin
      case (rd_addr)
        CP0_BADVADDR: rd_data = r_badvaddr;
        CP0_COUNT:    rd_data = w_count;
        CP0_COMPARE:  rd_data = w_compare;
        CP0_STATUS:   rd_data = w_status;
        CP0_CAUSE:    rd_data = w_cause;
        CP0_EPC:      rd_data = r_epc;
        default:      rd_data = '0;
      endcase
    end
  end

  assign epc         = r_epc;
  assign int_pending = r_ie & ~r_exl & (|(w_ip & r_im));

endmodule
